// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring divider, 16-bit unsigned dividend by
// 8-bit unsigned divisor, one quotient bit per clock (MSB first) behind a
// start/ready/done handshake. Divide-by-zero short-circuits to DONE with an
// all-ones quotient and the div_zero flag raised.
module seq_divider #(
  parameter int DW = 16,
  parameter int VW = 8,
  parameter int CW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          ready,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic [CW-1:0] LAST = CW'(DW - 1);

  state_t        state, state_nxt;
  logic [DW-1:0] q_reg;
  logic [VW-1:0] d_reg;
  logic [VW-1:0] r_reg;
  logic [CW-1:0] cnt;

  logic [VW:0]   shifted;
  logic          borrow;
  logic [VW-1:0] r_step;
  logic [DW-1:0] q_step;
  logic          last_step;

  // One restoring step: shift the next dividend bit into the partial
  // remainder and subtract the divisor if it fits. The partial remainder is
  // always below the divisor, so a successful subtraction fits in VW bits and
  // only the shifted value needs the extra bit.
  always_comb begin
    shifted   = {r_reg, q_reg[DW-1]};
    borrow    = (shifted < {1'b0, d_reg});
    r_step    = borrow ? shifted[VW-1:0] : (shifted[VW-1:0] - d_reg);
    q_step    = {q_reg[DW-2:0], ~borrow};
    last_step = (cnt >= LAST);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and handshake outputs; out-of-range counts end the run early.
  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) state_nxt = (divisor == '0) ? DONE : RUN;
      end
      RUN: begin
        if (last_step) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Working registers and result registers; results only move on the edge
  // that enters DONE so they hold between operations.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_reg     <= '0;
      d_reg     <= '0;
      r_reg     <= '0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            q_reg <= dividend;
            d_reg <= divisor;
            r_reg <= '0;
            cnt   <= '0;
            if (divisor == '0) begin
              quotient  <= '1;
              remainder <= '0;
              div_zero  <= 1'b1;
            end
          end
        end
        RUN: begin
          q_reg <= q_step;
          r_reg <= r_step;
          cnt   <= cnt + CW'(1);
          if (last_step) begin
            quotient  <= q_step;
            remainder <= r_step;
            div_zero  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: self-checking bench for seq_divider. Expected results come
// from plain integer division and the division identity.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        ready;
  logic        done;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        div_zero;

  int tests = 0;
  int fails = 0;

  seq_divider dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .ready     (ready),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  // Free-running clock, 10 time-unit period.
  always #5 clk = ~clk;

  // Drives one operation from a falling edge and reports what was observed:
  // results at the done cycle, done latency, whether ready rose too early,
  // and done/ready one cycle after done. Returns on the falling edge after done.
  task automatic run_op(input logic [15:0] a, input logic [7:0] b,
                        output logic [15:0] gq, output logic [7:0] gr,
                        output logic gdz, output int cycles, output int waited,
                        output bit ready_leak, output logic done_after,
                        output logic ready_after);
    waited = 0;
    while (!ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = 16'($urandom);
    divisor  = 8'($urandom);
    cycles     = 0;
    ready_leak = 1'b0;
    do begin
      @(negedge clk);
      cycles++;
      if (ready) ready_leak = 1'b1;
    end while (!done && cycles < 40);
    gq  = quotient;
    gr  = remainder;
    gdz = div_zero;
    @(negedge clk);
    done_after  = done;
    ready_after = ready;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    #12;
    tests++; if (ready !== 1'b1) begin fails++; $display("[TB] FAIL reset_ready: got %0b, expected 1", ready); end
    tests++; if (done !== 1'b0) begin fails++; $display("[TB] FAIL reset_done: got %0b, expected 0", done); end
    tests++; if (quotient !== 16'd0) begin fails++; $display("[TB] FAIL reset_quotient: got %0d, expected 0", quotient); end
    tests++; if (remainder !== 8'd0) begin fails++; $display("[TB] FAIL reset_remainder: got %0d, expected 0", remainder); end
    tests++; if (div_zero !== 1'b0) begin fails++; $display("[TB] FAIL reset_div_zero: got %0b, expected 0", div_zero); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests++; if (ready !== 1'b1) begin fails++; $display("[TB] FAIL idle_ready: got %0b, expected 1", ready); end
  endtask

  task automatic test_directed();
    logic [15:0] as [4] = '{16'd1000, 16'hFFFF, 16'hFFFF, 16'd5};
    logic [7:0]  bs [4] = '{8'd7, 8'hFF, 8'd1, 8'd9};
    logic [15:0] gq; logic [7:0] gr; logic gdz, da, ra; int cyc, w; bit leak;
    logic [15:0] eq; logic [7:0] er;
    for (int i = 0; i < 4; i++) begin
      eq = as[i] / 16'(bs[i]);
      er = 8'(as[i] % 16'(bs[i]));
      run_op(as[i], bs[i], gq, gr, gdz, cyc, w, leak, da, ra);
      tests++; if (gq !== eq) begin fails++; $display("[TB] FAIL dir_quotient[%0d]: got %0d, expected %0d", i, gq, eq); end
      tests++; if (gr !== er) begin fails++; $display("[TB] FAIL dir_remainder[%0d]: got %0d, expected %0d", i, gr, er); end
      tests++; if (gdz !== 1'b0) begin fails++; $display("[TB] FAIL dir_div_zero[%0d]: got %0b, expected 0", i, gdz); end
      tests++; if (cyc != 17) begin fails++; $display("[TB] FAIL dir_latency[%0d]: got %0d, expected 17", i, cyc); end
      tests++; if (leak) begin fails++; $display("[TB] FAIL dir_ready_busy[%0d]: got 1, expected 0", i); end
      tests++; if (da !== 1'b0 || ra !== 1'b1) begin fails++; $display("[TB] FAIL dir_after_done[%0d]: got done=%0b ready=%0b, expected done=0 ready=1", i, da, ra); end
      tests++; if (quotient !== eq) begin fails++; $display("[TB] FAIL dir_hold[%0d]: got %0d, expected %0d", i, quotient, eq); end
    end
  endtask

  task automatic test_div_zero();
    logic [15:0] gq; logic [7:0] gr; logic gdz, da, ra; int cyc, w; bit leak;
    run_op(16'd1234, 8'd0, gq, gr, gdz, cyc, w, leak, da, ra);
    tests++; if (gq !== 16'hFFFF) begin fails++; $display("[TB] FAIL dz_quotient: got %0h, expected ffff", gq); end
    tests++; if (gr !== 8'd0) begin fails++; $display("[TB] FAIL dz_remainder: got %0d, expected 0", gr); end
    tests++; if (gdz !== 1'b1) begin fails++; $display("[TB] FAIL dz_flag: got %0b, expected 1", gdz); end
    tests++; if (cyc != 1) begin fails++; $display("[TB] FAIL dz_latency: got %0d, expected 1", cyc); end
    tests++; if (da !== 1'b0 || ra !== 1'b1) begin fails++; $display("[TB] FAIL dz_after_done: got done=%0b ready=%0b, expected done=0 ready=1", da, ra); end
    tests++; if (div_zero !== 1'b1) begin fails++; $display("[TB] FAIL dz_hold: got %0b, expected 1", div_zero); end
    run_op(16'd100, 8'd10, gq, gr, gdz, cyc, w, leak, da, ra);
    tests++; if (gq !== 16'd10 || gr !== 8'd0) begin fails++; $display("[TB] FAIL dz_next_result: got q=%0d r=%0d, expected q=10 r=0", gq, gr); end
    tests++; if (gdz !== 1'b0) begin fails++; $display("[TB] FAIL dz_next_flag: got %0b, expected 0", gdz); end
  endtask

  task automatic test_ignore_start();
    int done_count = 0;
    int done_cycle = 0;
    logic [15:0] gq = '0; logic [7:0] gr = '0;
    @(negedge clk);
    start = 1'b1; dividend = 16'd500; divisor = 8'd3;
    @(posedge clk);
    #1;
    start = 1'b0; dividend = 16'($urandom); divisor = 8'($urandom);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (done) begin
        done_count++;
        if (done_count == 1) begin done_cycle = c; gq = quotient; gr = remainder; end
      end
      if (c == 5) begin start = 1'b1; dividend = 16'd9; divisor = 8'd2; end
      if (c == 6) begin dividend = 16'd7777; divisor = 8'd5; end
      if (c == 8) start = 1'b0;
    end
    tests++; if (gq !== 16'd166 || gr !== 8'd2) begin fails++; $display("[TB] FAIL ign_result: got q=%0d r=%0d, expected q=166 r=2", gq, gr); end
    tests++; if (done_cycle != 17) begin fails++; $display("[TB] FAIL ign_latency: got %0d, expected 17", done_cycle); end
    tests++; if (done_count != 1) begin fails++; $display("[TB] FAIL ign_done_count: got %0d, expected 1", done_count); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] gq; logic [7:0] gr; logic gdz, da, ra; int cyc, w; bit leak;
    run_op(16'd60000, 8'd77, gq, gr, gdz, cyc, w, leak, da, ra);
    tests++; if (gq !== 16'd779 || gr !== 8'd17) begin fails++; $display("[TB] FAIL b2b_first: got q=%0d r=%0d, expected q=779 r=17", gq, gr); end
    run_op(16'd4321, 8'd13, gq, gr, gdz, cyc, w, leak, da, ra);
    tests++; if (w != 0) begin fails++; $display("[TB] FAIL b2b_wait: got %0d, expected 0", w); end
    tests++; if (gq !== 16'd332 || gr !== 8'd5) begin fails++; $display("[TB] FAIL b2b_second: got q=%0d r=%0d, expected q=332 r=5", gq, gr); end
  endtask

  task automatic test_reset_midop();
    int done_count = 0;
    logic [15:0] gq; logic [7:0] gr; logic gdz, da, ra; int cyc, w; bit leak;
    @(negedge clk);
    start = 1'b1; dividend = 16'd40000; divisor = 8'd200;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests++; if (quotient !== 16'd0 || remainder !== 8'd0 || div_zero !== 1'b0) begin fails++; $display("[TB] FAIL mid_reset_results: got q=%0d r=%0d dz=%0b, expected 0 0 0", quotient, remainder, div_zero); end
    tests++; if (ready !== 1'b1 || done !== 1'b0) begin fails++; $display("[TB] FAIL mid_reset_handshake: got ready=%0b done=%0b, expected 1 0", ready, done); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (25) begin
      @(negedge clk);
      if (done) done_count++;
    end
    tests++; if (done_count != 0) begin fails++; $display("[TB] FAIL mid_reset_no_done: got %0d, expected 0", done_count); end
    run_op(16'd77, 8'd7, gq, gr, gdz, cyc, w, leak, da, ra);
    tests++; if (gq !== 16'd11 || gr !== 8'd0) begin fails++; $display("[TB] FAIL mid_reset_next: got q=%0d r=%0d, expected q=11 r=0", gq, gr); end
  endtask

  task automatic test_random();
    logic [15:0] ca [4] = '{16'd0, 16'hFFFF, 16'd1, 16'h8000};
    logic [7:0]  cb [4] = '{8'd0, 8'hFF, 8'd1, 8'h80};
    logic [15:0] a, gq; logic [7:0] b, gr; logic gdz, da, ra; int cyc, w; bit leak;
    int unsigned prod;
    for (int i = 0; i < 2000; i++) begin
      if (i < 16) begin a = ca[i / 4]; b = cb[i % 4]; end
      else begin a = 16'($urandom); b = 8'($urandom_range(0, 255)); end
      run_op(a, b, gq, gr, gdz, cyc, w, leak, da, ra);
      if (b == 8'd0) begin
        tests++; if (gq !== 16'hFFFF || gr !== 8'd0 || gdz !== 1'b1) begin fails++; $display("[TB] FAIL rnd_zero[%0d]: got q=%0h r=%0d dz=%0b, expected q=ffff r=0 dz=1", i, gq, gr, gdz); end
        tests++; if (cyc != 1) begin fails++; $display("[TB] FAIL rnd_zero_latency[%0d]: got %0d, expected 1", i, cyc); end
      end else begin
        prod = int'(gq) * int'(b) + int'(gr);
        tests++; if (prod != int'(a) || gr >= b) begin fails++; $display("[TB] FAIL rnd_invariant[%0d]: got q=%0d r=%0d for %0d/%0d, expected q*d+r=%0d and r<d", i, gq, gr, a, b, a); end
        tests++; if (gq !== a / 16'(b) || gdz !== 1'b0) begin fails++; $display("[TB] FAIL rnd_quotient[%0d]: got q=%0d dz=%0b, expected q=%0d dz=0", i, gq, gdz, a / 16'(b)); end
        tests++; if (cyc != 17) begin fails++; $display("[TB] FAIL rnd_latency[%0d]: got %0d, expected 17", i, cyc); end
      end
      tests++; if (leak || da !== 1'b0 || ra !== 1'b1) begin fails++; $display("[TB] FAIL rnd_handshake[%0d]: got leak=%0b done_after=%0b ready_after=%0b, expected 0 0 1", i, leak, da, ra); end
    end
  endtask

  // Runs every scenario in order and prints the summary.
  initial begin
    test_reset();
    test_directed();
    test_div_zero();
    test_ignore_start();
    test_back_to_back();
    test_reset_midop();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
